// File: rtl/mem_pkg.sv
// Shared types for the memory-stage data-bus master and its lane-alignment helper.
package mem_pkg;

    typedef logic bool;

    localparam bool TRUE  = 1'b1;
    localparam bool FALSE = 1'b0;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } mem_size_e;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        REQ      = 3'd1,
        WAIT_RSP = 3'd2,
        DONE     = 3'd3,
        DRAIN    = 3'd4
    } mem_state_e;

    // The raw size code 3 is illegal; it is folded onto a word access.
    function automatic mem_size_e decodeSize(input logic [1:0] rawSize);
        case (rawSize)
            2'd0:    return SZ_BYTE;
            2'd1:    return SZ_HALF;
            default: return SZ_WORD;
        endcase
    endfunction

    function automatic bool isMisaligned(input mem_size_e size, input logic [1:0] addrLo);
        case (size)
            SZ_HALF: return addrLo[0];
            SZ_WORD: return (addrLo != 2'b00);
            default: return FALSE;
        endcase
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Purely combinational byte-lane helper: store byte enables and lane
// replication, plus load lane extraction with zero/sign extension.
// Shared with the store buffer, so it holds no state.
module mem_lane_align
    import mem_pkg::*;
(
    input  mem_size_e   i_size,
    input  logic [1:0]  i_addrLo,
    input  bool         i_signed,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rdata,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic [31:0] o_rdata
);

    logic [31:0] w_shifted;

    assign w_shifted = i_rdata >> {i_addrLo, 3'b000};

    // Store side: pick the enabled lanes and replicate the right-aligned data into every lane.
    always_comb begin
        o_be    = 4'b1111;
        o_wdata = i_wdata;
        case (i_size)
            SZ_BYTE: begin
                o_be    = 4'b0001 << i_addrLo;
                o_wdata = {4{i_wdata[7:0]}};
            end
            SZ_HALF: begin
                o_be    = 4'b0011 << i_addrLo;
                o_wdata = {2{i_wdata[15:0]}};
            end
            default: begin
                o_be    = 4'b1111;
                o_wdata = i_wdata;
            end
        endcase
    end

    // Load side: bring the addressed lane down to bit 0, then zero- or sign-extend it.
    always_comb begin
        o_rdata = i_rdata;
        case (i_size)
            SZ_BYTE: o_rdata = {{24{i_signed & w_shifted[7]}}, w_shifted[7:0]};
            SZ_HALF: o_rdata = {{16{i_signed & w_shifted[15]}}, w_shifted[15:0]};
            default: o_rdata = i_rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Memory-stage data-bus master: runs one load/store per EX/MEM op, raises the
// memory stall to the pipeline controller, and honours its hold/flush.
// Optional watchdog: define MEM_TIMEOUT_EN to abort stuck transactions with bus_error.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
)
(
    input  logic              clk,
    input  logic              rst_n,
    input  bool               op_valid,
    input  bool               op_is_store,
    input  logic [1:0]        op_size,
    input  bool               op_signed,
    input  logic [ADDR_W-1:0] op_addr,
    input  logic [DATA_W-1:0] op_wdata,
    input  bool               stall_to_mem_cmt,
    input  bool               flash_to_mem_cmt,
    output bool               stall_from_memory,
    output bool               bus_req,
    output bool               bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [3:0]        bus_be,
    output logic [DATA_W-1:0] bus_wdata,
    input  bool               bus_gnt,
    input  bool               bus_rvalid,
    input  logic [DATA_W-1:0] bus_rdata,
    output bool               res_valid,
    output logic [DATA_W-1:0] res_data,
    output bool               addr_error,
    output bool               bus_error
);

    if (DATA_W != 32 || TIMEOUT_CYCLES < 1) begin : g_paramCheck
        $error("mem_access_unit: DATA_W must be 32 and TIMEOUT_CYCLES must be positive");
    end

    mem_state_e        r_state;
    mem_state_e        w_stateNext;
    bool               r_isStore;
    bool               r_signed;
    mem_size_e         r_size;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_result;
    logic [3:0]        w_be;
    logic [DATA_W-1:0] w_wdataRep;
    logic [DATA_W-1:0] w_loadData;
    bool               w_misaligned;
    bool               w_timeout;

    assign w_misaligned = isMisaligned(decodeSize(op_size), op_addr[1:0]);

    mem_lane_align u_laneAlign (
        .i_size   (r_size),
        .i_addrLo (r_addr[1:0]),
        .i_signed (r_signed),
        .i_wdata  (r_wdata),
        .i_rdata  (bus_rdata),
        .o_be     (w_be),
        .o_wdata  (w_wdataRep),
        .o_rdata  (w_loadData)
    );

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] r_wdogCnt;
    bool              r_busError;

    assign w_timeout = (r_wdogCnt == CNT_W'(TIMEOUT_CYCLES));
    assign bus_error = (r_state == DONE) && r_busError;

    // Watchdog counts only while a bus transaction is outstanding and restarts on every state entry.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wdogCnt <= '0;
        end else if ((w_stateNext != r_state) || !((r_state == REQ) || (r_state == WAIT_RSP))) begin
            r_wdogCnt <= '0;
        end else begin
            r_wdogCnt <= r_wdogCnt + 1'b1;
        end
    end

    // Remember that DONE was reached by expiry rather than by a real response.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_busError <= FALSE;
        end else if ((r_state == IDLE) && (w_stateNext == REQ)) begin
            r_busError <= FALSE;
        end else if (((r_state == REQ) || (r_state == WAIT_RSP)) && (w_stateNext == DONE) &&
                     !((r_state == WAIT_RSP) && bus_rvalid)) begin
            r_busError <= TRUE;
        end
    end
`else
    assign w_timeout = FALSE;
    assign bus_error = FALSE;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Next state: a flush always wins, and a flush that races a grant still owes a DRAIN.
    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            IDLE: begin
                if (op_valid && !w_misaligned && !flash_to_mem_cmt) w_stateNext = REQ;
            end
            REQ: begin
                if (flash_to_mem_cmt)  w_stateNext = bus_gnt ? DRAIN : IDLE;
                else if (bus_gnt)      w_stateNext = WAIT_RSP;
                else if (w_timeout)    w_stateNext = DONE;
            end
            WAIT_RSP: begin
                if (flash_to_mem_cmt)  w_stateNext = bus_rvalid ? IDLE : DRAIN;
                else if (bus_rvalid)   w_stateNext = DONE;
                else if (w_timeout)    w_stateNext = DONE;
            end
            DONE: begin
                if (flash_to_mem_cmt || !stall_to_mem_cmt) w_stateNext = IDLE;
            end
            DRAIN: begin
                if (bus_rvalid) w_stateNext = IDLE;
            end
            default: w_stateNext = IDLE;
        endcase
    end

    // Op latch and result register; the result is cleared at launch so stores and expiries return 0.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_isStore <= FALSE;
            r_signed  <= FALSE;
            r_size    <= SZ_BYTE;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_result  <= '0;
        end else if ((r_state == IDLE) && (w_stateNext == REQ)) begin
            r_isStore <= op_is_store;
            r_signed  <= op_signed;
            r_size    <= decodeSize(op_size);
            r_addr    <= op_addr;
            r_wdata   <= op_wdata;
            r_result  <= '0;
        end else if ((r_state == WAIT_RSP) && bus_rvalid && !flash_to_mem_cmt) begin
            r_result  <= r_isStore ? '0 : w_loadData;
        end
    end

    // Outputs: stall covers the launch cycle and the outstanding bus phases; bus fields only show in REQ.
    always_comb begin
        stall_from_memory = FALSE;
        bus_req           = FALSE;
        bus_we            = FALSE;
        bus_addr          = '0;
        bus_be            = 4'b0000;
        bus_wdata         = '0;
        res_valid         = FALSE;
        res_data          = '0;
        addr_error        = FALSE;
        case (r_state)
            IDLE: begin
                if (op_valid && w_misaligned) begin
                    addr_error = TRUE;
                    res_valid  = TRUE;
                end else if (op_valid && !flash_to_mem_cmt) begin
                    stall_from_memory = TRUE;
                end
            end
            REQ: begin
                stall_from_memory = TRUE;
                bus_req           = TRUE;
                bus_we            = r_isStore;
                bus_addr          = {r_addr[ADDR_W-1:2], 2'b00};
                bus_be            = w_be;
                bus_wdata         = w_wdataRep;
            end
            WAIT_RSP: begin
                stall_from_memory = TRUE;
            end
            DONE: begin
                res_valid = TRUE;
                res_data  = r_result;
            end
            default: begin
                stall_from_memory = FALSE;
            end
        endcase
    end

endmodule
